// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide widths, constants and the fetch buffer entry type.
//   XLEN          - address/register width
//   ILEN          - instruction word width
//   NOP_INSTR     - canonical no-op (addi x0, x0, 0)
//   fetch_entry_t - {pc, instr} pair held in the fetch buffer
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's ROM port, redirect port and
// decode-side valid/ready handshake.
//   rom_req/rom_addr      fetch -> ROM   read strobe and byte address
//   rom_rdata             ROM -> fetch   word, one cycle after rom_req
//   redirect_valid/_pc    execute -> fetch   PC change request
//   instr_valid/_data/_pc fetch -> decode    buffered head instruction
//   instr_ready           decode -> fetch    head accepted this cycle
// master: the fetch unit side; slave: the surrounding ROM/execute/decode side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            rom_req;
  logic [XLEN-1:0] rom_addr;
  logic [ILEN-1:0] rom_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output rom_req, rom_addr, instr_valid, instr_data, instr_pc,
    input  rom_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_req, rom_addr, instr_valid, instr_data, instr_pc,
    output rom_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small instruction buffer of {pc, instr} entries.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - synchronous flush (redirect)
//   push        - write push_data at the tail
//   pop         - drop the head (caller guarantees non-empty)
//   head        - current head entry (undefined when count == 0)
//   count       - number of valid entries, 0..DEPTH
// Simultaneous push and pop is allowed at any occupancy; the caller's credit
// scheme guarantees no push is issued into a full buffer without a pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // Storage has no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between program ROM and decode.
//   RESET_PC    - first fetch address after reset
//   FIFO_DEPTH  - instruction buffer entries (power of two, >= 2)
//   clk, reset  - clock, synchronous active-high reset
//   bus         - fetch_unit_if.master: ROM read port, redirect input and
//                 decode valid/ready handshake
// Issues one sequential ROM read per cycle while buffer credit allows,
// buffers {pc, word} pairs and flushes everything on a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            pop;
  logic            push;
  logic            valid;
  logic [CW:0]     occupancy;
  logic [CW:0]     limit;

  assign valid = (count != '0);
  assign pop   = valid && bus.instr_ready;

  // Credit check: count + inflight - pop < FIFO_DEPTH, rearranged to
  // avoid underflow as count + inflight < FIFO_DEPTH + pop.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign limit     = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};

  assign bus.rom_req  = !reset && !bus.redirect_valid && (occupancy < limit);
  assign bus.rom_addr = fetch_pc;

  // Returning word is discarded when a redirect lands in the same cycle.
  assign push       = inflight && !bus.redirect_valid;
  assign push_entry = '{pc: inflight_pc, instr: bus.rom_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight    <= 1'b0;
    end else if (bus.rom_req) begin
      fetch_pc    <= fetch_pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.instr_valid = valid;
  assign bus.instr_data  = valid ? head.instr : '0;
  assign bus.instr_pc    = valid ? head.pc    : '0;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting between the program ROM (loaded from the `.mem` image) and the CPU decode stage inside `soc`. It generates sequential fetch addresses, issues one ROM read per cycle, buffers returned words with their PCs in a small FIFO, and hands them to decode over a valid/ready handshake. It also handles PC redirects from execute (branches/jumps) by flushing buffered and in-flight instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; power of two, at least 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rom_req`  out  1  ROM read strobe.
- `rom_addr`  out  32  byte address of the read; bits [1:0] always 0.
- `rom_rdata`  in  32  ROM word, valid the cycle after `rom_req`.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (forced to 0).
- `instr_valid`  out  1  FIFO head holds an instruction.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instr_data`  out  32  head instruction word; 0 when `instr_valid`=0.
- `instr_pc`  out  32  PC of the head instruction; 0 when `instr_valid`=0.

## Operation
- State: `fetch_pc` (32), FIFO of {pc, word} with `count`, 1-bit `inflight`, `inflight_pc`.
- `rom_addr` = `fetch_pc`.
- `rom_req` = !reset && !redirect_valid && (count + inflight − pop < FIFO_DEPTH), where pop = instr_valid && instr_ready.
- On a `rom_req` cycle: `fetch_pc` += 4 (wraps modulo 2^32), `inflight` <= 1, `inflight_pc` <= `fetch_pc`. Otherwise `inflight` <= 0.
- When `inflight`=1 and no redirect: push {inflight_pc, rom_rdata} into the FIFO at the end of that cycle.
- Pop on instr_valid && instr_ready. Simultaneous push and pop is legal at any count. The credit rule guarantees the FIFO never overflows.
- Redirect has priority over everything else. In that cycle:
  - `fetch_pc` <= redirect_pc & ~3, FIFO is cleared, `inflight` <= 0, and the returning `rom_rdata` is discarded.
  - `rom_req` is 0.
  - A handshake that coincides with the redirect counts as consumed by decode.
- No FSM beyond the states above. Stalls come only from the credit rule.

## Timing
- Reset values: rom_req 0, rom_addr RESET_PC, instr_valid 0, instr_data 0, instr_pc 0, count 0, inflight 0.
- First cycle after reset deasserts (cycle 0): rom_req=1 at RESET_PC. The word is pushed at the end of cycle 1, so instr_valid=1 in cycle 2.
- Request to instr_valid latency: 2 cycles. There is no bypass path from `rom_rdata` to `instr_data`.
- Redirect asserted in cycle t: first request to the target in cycle t+1, and its instruction is valid in cycle t+3.
- Throughput: one instruction per cycle while `instr_ready`=1 continuously.
- Decode stall: FIFO fills to FIFO_DEPTH and `rom_req` drops. Fetch resumes in the same cycle as the next pop.
- Reset mid-operation: reset wins over redirect and handshake. A ROM response arriving in the cycle after reset is dropped.

## Structure
- Shared package `cpu_pkg`: XLEN=32, ILEN=32, `NOP_INSTR` = 32'h0000_0013, and a `fetch_entry_t` {pc, instr} typedef.
- One sub-module, `fetch_fifo`: parameterised depth, synchronous clear, push/pop, count output.
- Counter, credit and redirect logic live in `fetch_unit`.

## Test plan
- Reset, ROM words 0x00500393, 0x40738433, 0x00000013 at 0/4/8, instr_ready=1 -> instr_valid from cycle 2; (pc, data) = (0, 0x00500393), (4, 0x40738433), (8, 0x00000013) on consecutive cycles.
- instr_ready=0 for 6 cycles after reset -> count saturates at 2 and rom_req goes low. On release, pcs continue 0, 4, 8, 12 with no gaps or duplicates.
- redirect_valid with redirect_pc=0x20 while FIFO is full and a read is in flight -> the next instruction seen is pc 0x20, valid 3 cycles later, with no stale pcs delivered.
- redirect_pc=0x23 -> first rom_addr 0x20.
- Reset asserted mid-stream with a read in flight -> outputs return to reset values, and the first instruction after release is RESET_PC (also test RESET_PC=0x100).
- fetch_pc preloaded near 0xFFFF_FFF8 via redirect -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
